// File: rtl/poly_uniform_acc.sv
// poly_uniform_acc: gathers batches of coefficients from rej_uniform into one
// N-entry polynomial, one coefficient per cycle, saturating at N entries.
// Optional feature macro: POLY_UNIFORM_ACC_RANGE_CHECK_EN (sticky range_err on
// any accepted coefficient < 0 or >= Q). Without it range_err is tied low.
// Index arithmetic assumes N is a power of two.
module poly_uniform_acc #(
    parameter int N = 256,
    parameter int Q = 8380417
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              batch_rdy,
    input  logic [32*N-1:0]   linear_a,
    input  logic [31:0]       ctr,
    output logic              batch_done,
    output logic [31:0]       rem_len,
    output logic [32*N-1:0]   linear_poly,
    output logic              poly_rts,
    output logic              range_err
);

    localparam int KW = $clog2(N + 1);
    localparam int PW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BATCH,
        S_COPY,
        S_ACK,
        S_FULL
    } state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         fill_q, fill_d;
    logic [KW-1:0]         k_q, k_d;
    logic [KW-1:0]         take_q, take_d;
    logic                  batch_done_q, batch_done_d;
    logic                  poly_rts_q, poly_rts_d;
    logic [31:0]           rem_len_q, rem_len_d;
    logic [32*N-1:0]       poly_q;
    logic signed [31:0]    coef_sel;
    logic                  copy_en;
    logic                  restart;

    // A zero or negative modulus makes the range check meaningless.
    if (Q <= 0) begin : g_bad_q
        $error("poly_uniform_acc: Q must be positive");
    end

    // Next-state logic: batch handshake, copy counter and saturating fill.
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        k_d          = k_q;
        take_d       = take_q;
        copy_en      = 1'b0;
        restart      = 1'b0;
        // k < take <= N whenever the selected coefficient is consumed.
        coef_sel     = linear_a[{k_q[PW-1:0], 5'b00000} +: 32];
        case (state_q)
            S_IDLE, S_FULL: begin
                if (start) begin
                    restart = 1'b1;
                    fill_d  = '0;
                    state_d = S_WAIT_BATCH;
                end
            end
            S_WAIT_BATCH: begin
                if (start) begin
                    restart = 1'b1;
                    fill_d  = '0;
                end else if (batch_rdy) begin
                    // rem_len_q always equals N - fill, so this clamps fill at N.
                    take_d  = (ctr < rem_len_q) ? KW'(ctr) : KW'(rem_len_q);
                    k_d     = '0;
                    state_d = S_COPY;
                end
            end
            S_COPY: begin
                if (k_q < take_q) begin
                    copy_en = 1'b1;
                    fill_d  = fill_q + KW'(1);
                    k_d     = k_q + KW'(1);
                end else begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!batch_rdy) begin
                    state_d = (fill_q == KW'(N)) ? S_FULL : S_WAIT_BATCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
        batch_done_d = (state_d == S_ACK);
        poly_rts_d   = (state_d == S_FULL);
        rem_len_d    = 32'(N) - 32'(fill_d);
    end

    // Control state and registered outputs; the async reset acts even mid-copy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fill_q       <= '0;
            k_q          <= '0;
            take_q       <= '0;
            batch_done_q <= 1'b0;
            poly_rts_q   <= 1'b0;
            rem_len_q    <= 32'(N);
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            k_q          <= k_d;
            take_q       <= take_d;
            batch_done_q <= batch_done_d;
            poly_rts_q   <= poly_rts_d;
            rem_len_q    <= rem_len_d;
        end
    end

    // Coefficient storage, deliberately not reset; entries past fill are stale.
    always_ff @(posedge clock) begin
        if (copy_en) begin
            poly_q[{fill_q[PW-1:0], 5'b00000} +: 32] <= coef_sel;
        end
    end

`ifdef POLY_UNIFORM_ACC_RANGE_CHECK_EN
    logic range_err_q, range_err_d;

    // Sticky out-of-range flag, cleared only by an accepted start or reset.
    always_comb begin
        range_err_d = range_err_q;
        if (restart) begin
            range_err_d = 1'b0;
        end else if (copy_en && ((coef_sel < 0) || (coef_sel >= Q))) begin
            range_err_d = 1'b1;
        end
    end

    // Range flag register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign range_err = range_err_q;
`else
    logic unused_restart;
    assign unused_restart = restart;
    assign range_err      = 1'b0;
`endif

    assign batch_done  = batch_done_q;
    assign poly_rts    = poly_rts_q;
    assign rem_len     = rem_len_q;
    assign linear_poly = poly_q;

endmodule

// File: tb/tb_poly_uniform_acc.sv
// Self-checking bench for poly_uniform_acc (N=256). Expected coefficients are
// queued when a batch is driven and compared once the polynomial is complete.
module tb_poly_uniform_acc;

    localparam int N  = 256;
    localparam int QV = 8380417;

    logic              clock;
    logic              reset;
    logic              start;
    logic              batch_rdy;
    logic [32*N-1:0]   linear_a;
    logic [31:0]       ctr;
    logic              batch_done;
    logic [31:0]       rem_len;
    logic [32*N-1:0]   linear_poly;
    logic              poly_rts;
    logic              range_err;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   m_fill;
    int   n_vec;
    int   n_err;

    poly_uniform_acc #(.N(N), .Q(QV)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .batch_rdy   (batch_rdy),
        .linear_a    (linear_a),
        .ctr         (ctr),
        .batch_done  (batch_done),
        .rem_len     (rem_len),
        .linear_poly (linear_poly),
        .poly_rts    (poly_rts),
        .range_err   (range_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [32*N-1:0] mk_ramp(input int base);
        logic [32*N-1:0] v;
        for (int k = 0; k < N; k++) v[32*k +: 32] = 32'(base + k);
        return v;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_fill = 0;
        sb_q.delete();
    endtask

    // Drive one batch, queue the expected writes, and count cycles until batch_done.
    task automatic send_batch(input logic [32*N-1:0] a, input int c, input int start_at,
                              output int cycles);
        int take;
        take = (c < N - m_fill) ? c : N - m_fill;
        for (int k = 0; k < take; k++) sb_q.push_back('{m_fill + k, a[32*k +: 32]});
        m_fill += take;
        linear_a  = a;
        ctr       = 32'(c);
        batch_rdy = 1'b1;
        cycles    = 0;
        while (1) begin
            start = (cycles == start_at);
            tick();
            cycles++;
            if (batch_done) break;
            if (cycles > 600) begin
                cycles = -1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic release_batch();
        batch_rdy = 1'b0;
        tick();
    endtask

    task automatic drain_sb(input string name);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (linear_poly[32*e.idx +: 32] !== e.val) begin
                n_err++;
                $display("FAIL %s poly[%0d]: got %0d expected %0d", name, e.idx,
                         linear_poly[32*e.idx +: 32], e.val);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({batch_done, poly_rts, range_err} !== 3'b000 || rem_len !== 32'd256) begin
            n_err++;
            $display("FAIL reset_state: got done/rts/err=%b%b%b rem_len=%0d expected 000 256",
                     batch_done, poly_rts, range_err, rem_len);
        end
        reset = 1'b0;
        batch_rdy = 1'b1;
        ctr = 32'd5;
        linear_a = mk_ramp(0);
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (batch_done !== 1'b0 || rem_len !== 32'd256) begin
            n_err++;
            $display("FAIL idle_hold: got done=%b rem_len=%0d expected 0 256", batch_done, rem_len);
        end
        batch_rdy = 1'b0;
        tick();
    endtask

    task automatic test_full_batch();
        int cyc;
        pulse_start();
        send_batch(mk_ramp(0), 256, -1, cyc);
        n_vec++;
        if (cyc !== 258) begin
            n_err++;
            $display("FAIL full_latency: got %0d expected 258", cyc);
        end
        n_vec++;
        if (rem_len !== 32'd0) begin
            n_err++;
            $display("FAIL full_rem_len: got %0d expected 0", rem_len);
        end
        release_batch();
        n_vec++;
        if (poly_rts !== 1'b1 || batch_done !== 1'b0) begin
            n_err++;
            $display("FAIL full_rts: got rts=%b done=%b expected 1 0", poly_rts, batch_done);
        end
        drain_sb("full");
        // A new batch in FULL must be ignored and the polynomial must not move.
        linear_a = mk_ramp(9000);
        ctr = 32'd256;
        batch_rdy = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_vec++;
        if (poly_rts !== 1'b1 || batch_done !== 1'b0 || linear_poly[32*7 +: 32] !== 32'd7) begin
            n_err++;
            $display("FAIL full_stable: got rts=%b done=%b poly[7]=%0d expected 1 0 7",
                     poly_rts, batch_done, linear_poly[32*7 +: 32]);
        end
        batch_rdy = 1'b0;
        tick();
    endtask

    task automatic test_partial_batches();
        int cyc;
        int exp_rem[3] = '{156, 56, 0};
        int exp_cyc[3] = '{102, 102, 58};
        pulse_start();
        for (int b = 0; b < 3; b++) begin
            send_batch(mk_ramp(1000 * (b + 1)), 100, -1, cyc);
            n_vec++;
            if (cyc !== exp_cyc[b]) begin
                n_err++;
                $display("FAIL partial_latency[%0d]: got %0d expected %0d", b, cyc, exp_cyc[b]);
            end
            release_batch();
            n_vec++;
            if (rem_len !== 32'(exp_rem[b])) begin
                n_err++;
                $display("FAIL partial_rem_len[%0d]: got %0d expected %0d", b, rem_len, exp_rem[b]);
            end
        end
        n_vec++;
        if (poly_rts !== 1'b1 || linear_poly[32*255 +: 32] !== 32'd3055) begin
            n_err++;
            $display("FAIL partial_last: got rts=%b poly[255]=%0d expected 1 3055",
                     poly_rts, linear_poly[32*255 +: 32]);
        end
        drain_sb("partial");
    endtask

    task automatic test_zero_batch();
        int cyc;
        pulse_start();
        send_batch(mk_ramp(400), 0, -1, cyc);
        n_vec++;
        if (cyc !== 2 || rem_len !== 32'd256) begin
            n_err++;
            $display("FAIL zero_batch: got cycles=%0d rem_len=%0d expected 2 256", cyc, rem_len);
        end
        release_batch();
        n_vec++;
        if (poly_rts !== 1'b0 || batch_done !== 1'b0) begin
            n_err++;
            $display("FAIL zero_release: got rts=%b done=%b expected 0 0", poly_rts, batch_done);
        end
        // Back in WAIT_BATCH: an immediate batch must be accepted with normal latency.
        send_batch(mk_ramp(500), 4, -1, cyc);
        n_vec++;
        if (cyc !== 6 || rem_len !== 32'd252) begin
            n_err++;
            $display("FAIL zero_followup: got cycles=%0d rem_len=%0d expected 6 252", cyc, rem_len);
        end
        release_batch();
        drain_sb("zero");
    endtask

    task automatic test_reset_mid_copy();
        int cyc;
        pulse_start();
        linear_a  = mk_ramp(5000);
        ctr       = 32'd100;
        batch_rdy = 1'b1;
        for (int i = 0; i < 41; i++) tick();
        n_vec++;
        if (rem_len !== 32'd216) begin
            n_err++;
            $display("FAIL midcopy_fill: got rem_len=%0d expected 216", rem_len);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (rem_len !== 32'd256 || batch_done !== 1'b0 || poly_rts !== 1'b0 || range_err !== 1'b0) begin
            n_err++;
            $display("FAIL midcopy_async: got rem_len=%0d done=%b rts=%b err=%b expected 256 0 0 0",
                     rem_len, batch_done, poly_rts, range_err);
        end
        batch_rdy = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        pulse_start();
        n_vec++;
        if (rem_len !== 32'd256) begin
            n_err++;
            $display("FAIL midcopy_restart: got rem_len=%0d expected 256", rem_len);
        end
        send_batch(mk_ramp(6000), 10, -1, cyc);
        n_vec++;
        if (cyc !== 12 || rem_len !== 32'd246) begin
            n_err++;
            $display("FAIL midcopy_after: got cycles=%0d rem_len=%0d expected 12 246", cyc, rem_len);
        end
        release_batch();
        drain_sb("midcopy");
    endtask

    task automatic test_start_ignored();
        int cyc;
        pulse_start();
        send_batch(mk_ramp(7000), 256, 50, cyc);
        n_vec++;
        if (cyc !== 258 || rem_len !== 32'd0) begin
            n_err++;
            $display("FAIL start_in_copy: got cycles=%0d rem_len=%0d expected 258 0", cyc, rem_len);
        end
        release_batch();
        n_vec++;
        if (poly_rts !== 1'b1) begin
            n_err++;
            $display("FAIL start_in_copy_rts: got %b expected 1", poly_rts);
        end
        drain_sb("start_in_copy");
        pulse_start();
        n_vec++;
        if (poly_rts !== 1'b0 || rem_len !== 32'd256) begin
            n_err++;
            $display("FAIL start_in_full: got rts=%b rem_len=%0d expected 0 256", poly_rts, rem_len);
        end
    endtask

    task automatic test_range();
        int cyc;
        logic exp_err;
        logic [32*N-1:0] a;
`ifdef POLY_UNIFORM_ACC_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        pulse_start();
        a = mk_ramp(10);
        a[32*3 +: 32] = 32'd8380416;
        send_batch(a, 8, -1, cyc);
        release_batch();
        n_vec++;
        if (range_err !== 1'b0) begin
            n_err++;
            $display("FAIL range_qminus1: got %b expected 0", range_err);
        end
        a[32*3 +: 32] = 32'd8380417;
        send_batch(a, 8, -1, cyc);
        release_batch();
        for (int i = 0; i < 3; i++) tick();
        n_vec++;
        if (range_err !== exp_err) begin
            n_err++;
            $display("FAIL range_q: got %b expected %b", range_err, exp_err);
        end
        drain_sb("range");
        pulse_start();
        n_vec++;
        if (range_err !== 1'b0) begin
            n_err++;
            $display("FAIL range_clear: got %b expected 0", range_err);
        end
        a[32*3 +: 32] = 32'hFFFF_FFFF;
        send_batch(a, 8, -1, cyc);
        release_batch();
        n_vec++;
        if (range_err !== exp_err) begin
            n_err++;
            $display("FAIL range_neg: got %b expected %b", range_err, exp_err);
        end
        drain_sb("range_neg");
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_fill    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        batch_rdy = 1'b0;
        ctr       = '0;
        linear_a  = '0;
        test_reset();
        test_full_batch();
        test_partial_batches();
        test_zero_batch();
        test_reset_mid_copy();
        test_start_ignored();
        test_range();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/poly_uniform_acc.md
POLY_UNIFORM_ACC -- requirements
Module: poly_uniform_acc

Interface
REQ-001 Parameter N, default 256: number of coefficients in a polynomial.
REQ-002 Parameter Q, default 8380417: modulus, used only by the range check.
REQ-003 clock  input  1  single clock; all state on posedge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  1-cycle pulse; clears the accumulator and begins a new polynomial.
REQ-006 batch_rdy  input  1  level; linear_a/ctr hold a valid batch from rej_uniform (its rts).
REQ-007 linear_a  input  8192  batch coefficients; coef k = bits [32k+31:32k], signed 32-bit.
REQ-008 ctr  input  32  number of valid coefficients in linear_a, starting at k=0.
REQ-009 batch_done  output  1  batch consumed; held high until batch_rdy falls.
REQ-010 rem_len  output  32  N - fill; the len to request from the next rej_uniform call.
REQ-011 linear_poly  output  8192  accumulated polynomial; coef i = bits [32i+31:32i].
REQ-012 poly_rts  output  1  high while all N coefficients are filled.
REQ-013 range_err  output  1  sticky flag: a coefficient >= Q or < 0 was accepted.

Function
REQ-014 States SHALL be IDLE, WAIT_BATCH, COPY, ACK and FULL.
REQ-015 In IDLE, WAIT_BATCH or FULL, start SHALL set fill=0, clear range_err and enter WAIT_BATCH on the next edge.
REQ-016 start SHALL be ignored in COPY and ACK.
REQ-017 In WAIT_BATCH, batch_rdy=1 SHALL latch take = min(ctr, N-fill), set k=0 and enter COPY.
- ctr=0 SHALL produce take=0.
REQ-018 In COPY, each cycle with k<take SHALL write poly[fill] <= coef k, fill <= fill+1 and k <= k+1.
- Rate: exactly one coefficient per cycle.
- Coefficients k >= take SHALL be discarded.
REQ-019 COPY SHALL go to ACK on the cycle k==take; take=0 SHALL therefore spend one cycle in COPY.
REQ-020 In ACK, batch_done SHALL be 1.
- ACK SHALL stay until batch_rdy=0.
- On batch_rdy=0: go to FULL if fill==N, else to WAIT_BATCH.
REQ-021 batch_done SHALL be 0 in every state except ACK.
REQ-022 Latency from batch_rdy rising in WAIT_BATCH to batch_done=1 SHALL be take+2 cycles.
REQ-023 In FULL, poly_rts SHALL be 1; it SHALL be 0 in every other state.
REQ-024 In FULL, batch_rdy SHALL be ignored; only start leaves FULL.
REQ-025 rem_len SHALL be registered and equal N-fill at every cycle boundary; it SHALL never underflow.
REQ-026 fill SHALL saturate at N.
- If ctr > N-fill, exactly N-fill coefficients SHALL be copied.
- The remainder SHALL be dropped silently.
REQ-027 linear_poly entries at index >= fill SHALL hold stale values; consumers SHALL qualify linear_poly with poly_rts.
REQ-028 linear_poly SHALL remain stable while poly_rts=1.

Reset
REQ-029 reset=1 SHALL immediately force the following, regardless of state, including mid-COPY:
- state=IDLE
- fill=0, k=0, take=0
- batch_done=0, poly_rts=0, range_err=0
- rem_len=N
REQ-030 The poly storage array SHALL NOT be reset.
REQ-031 After reset is released, the block SHALL stay in IDLE until start.

Configuration
REQ-032 With macro POLY_UNIFORM_ACC_RANGE_CHECK_EN defined, each write in COPY SHALL set range_err if the coefficient is < 0 or >= Q.
- range_err SHALL stay set until start or reset.
REQ-033 Without POLY_UNIFORM_ACC_RANGE_CHECK_EN, range_err SHALL be tied to 0 and no comparator SHALL be synthesised.

Verification
REQ-034 Reset, start, one batch with ctr=256 and coef k=k -> batch_done after 258 cycles; then drop batch_rdy -> poly_rts=1, poly[i]=i, rem_len=0.
REQ-035 Batches with ctr=100, 100, 100 -> rem_len goes 156, 56, 0; third batch copies only 56; poly_rts=1; poly[255] = third batch coef 55.
REQ-036 Batch with ctr=0 -> batch_done after 2 cycles; rem_len unchanged at 256; state returns to WAIT_BATCH.
REQ-037 Assert reset asynchronously mid-COPY at fill=40 -> outputs cleared in the same cycle; start then fill=0, rem_len=256.
REQ-038 With the macro defined, a batch containing coef 8380417 -> range_err=1 until the next start; without the macro, range_err stays 0.
REQ-039 start pulsed during COPY -> ignored and the copy completes; start in FULL -> poly_rts=0 next cycle, rem_len=256.
